// File: rtl/i_instr_encoder_pkg.sv
// i_instr_encoder_pkg
// Shared constants and types for the I-type instruction encoder:
//   - 7-bit major opcodes for the three I-type classes we emit
//   - the canonical NOP (addi x0,x0,0) substituted for illegal bundles
//   - the 2-bit in_op encoding used on the field-bundle input
//   - funct3 values that matter for legality and shift handling
//   - a helper that tells whether a 32-bit value fits a signed 12-bit field
package i_instr_encoder_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'h13;
    localparam logic [6:0]  OPC_LOAD   = 7'h03;
    localparam logic [6:0]  OPC_JALR   = 7'h67;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    localparam logic [6:0]  FUNCT7_SRA = 7'b0100000;

    localparam logic [2:0]  F3_SLL     = 3'b001;
    localparam logic [2:0]  F3_SRL_SRA = 3'b101;

    typedef enum logic [1:0] {
        IN_OP_IMM  = 2'b00,
        IN_OP_LOAD = 2'b01,
        IN_OP_JALR = 2'b10,
        IN_OP_RSVD = 2'b11
    } in_op_e;

    // A value fits signed 12 bits when bits 31..11 are all copies of the sign.
    function automatic logic imm_fits12(input logic [31:0] imm);
        return (&imm[31:11]) | ~(|imm[31:11]);
    endfunction

endpackage

// File: rtl/i_instr_encoder_if.sv
// i_instr_encoder_if
// Bundles the field-input stream, the word-output stream and the
// start/error side-band of the I-type encoder.
//   master : the program loader / self-test generator side
//   slave  : the encoder itself
// Ports of the bundle:
//   start                         restart pulse (address reload, error clear)
//   in_valid/in_ready             field-bundle handshake
//   in_op, in_funct3, in_arith,
//   in_rd, in_rs1, in_imm         instruction fields
//   out_valid/out_ready           word handshake
//   out_word, out_addr, out_err   encoded word, its address, NOP-substituted flag
//   err_sticky, err_count         error summary since reset/start
interface i_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [2:0]        in_funct3;
    logic              in_arith;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic              err_sticky;
    logic [7:0]        err_count;

    modport master (
        output start, in_valid, in_op, in_funct3, in_arith, in_rd, in_rs1, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_word, out_addr, out_err, err_sticky, err_count
    );

    modport slave (
        input  start, in_valid, in_op, in_funct3, in_arith, in_rd, in_rs1, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_word, out_addr, out_err, err_sticky, err_count
    );
endinterface

// File: rtl/i_instr_encoder_pack.sv
// i_instr_pack
// Purely combinational packer: turns one I-type field bundle into a 32-bit
// instruction word and flags bundles that cannot be encoded legally.
// Ports:
//   op, funct3, arith, rd, rs1, imm   field bundle (arith only matters for
//                                     OP-IMM funct3=101, selecting SRAI)
//   word                              encoded word, NOP_WORD when err=1
//   err                               bundle was illegal
module i_instr_pack
    import i_instr_encoder_pkg::*;
(
    input  in_op_e      op,
    input  logic [2:0]  funct3,
    input  logic        arith,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    logic [6:0]  opcode;
    logic [11:0] imm12;
    logic        is_shift;
    logic        imm_ok;
    logic        shamt_ok;

    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    assign imm_ok   = imm_fits12(imm);
    assign shamt_ok = (imm[31:5] == '0);

    always_comb begin
        opcode = OPC_OP_IMM;
        imm12  = imm[11:0];
        err    = 1'b0;
        unique case (op)
            IN_OP_IMM: begin
                opcode = OPC_OP_IMM;
                if (is_shift) begin
                    // Shift immediates are {funct7, shamt}; only SRAI sets funct7.
                    imm12 = {((funct3 == F3_SRL_SRA) && arith) ? FUNCT7_SRA : 7'b0, imm[4:0]};
                    err   = !shamt_ok;
                end else begin
                    err   = !imm_ok;
                end
            end
            IN_OP_LOAD: begin
                opcode = OPC_LOAD;
                // LD/LWU/... do not exist in RV32I: funct3 011, 110, 111 are illegal.
                err    = !imm_ok || (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            IN_OP_JALR: begin
                opcode = OPC_JALR;
                err    = !imm_ok || (funct3 != 3'b000);
            end
            IN_OP_RSVD: begin
                err    = 1'b1;
            end
        endcase
    end

    assign word = err ? NOP_WORD : {imm12, rs1, funct3, rd, opcode};

endmodule

// File: rtl/i_instr_encoder.sv
// i_instr_encoder
// Streaming I-type encoder with a one-entry registered output stage, a
// sequential write-address counter and sticky/counted error reporting.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   i_instr_encoder_if.slave: field input stream, word output stream,
//         start pulse and error summary
// Parameters:
//   ADDR_W     width of out_addr
//   BASE_ADDR  address of the first word after reset or start
//   ADDR_STEP  address increment per emitted word
module i_instr_encoder
    import i_instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ADDR_STEP = 4
) (
    input  logic                clk,
    input  logic                rst,
    i_instr_encoder_if.slave    bus
);

    logic              out_valid_q,  out_valid_d;
    logic [31:0]       out_word_q,   out_word_d;
    logic              out_err_q,    out_err_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              err_sticky_q, err_sticky_d;
    logic [7:0]        err_count_q,  err_count_d;

    logic [31:0]       pack_word;
    logic              pack_err;
    logic              in_ready;
    logic              accept;
    logic              out_fire;

    i_instr_pack u_pack (
        .op     (in_op_e'(bus.in_op)),
        .funct3 (bus.in_funct3),
        .arith  (bus.in_arith),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .imm    (bus.in_imm),
        .word   (pack_word),
        .err    (pack_err)
    );

    // start wins over a same-cycle input, so it blocks acceptance outright.
    assign in_ready = (!out_valid_q || bus.out_ready) && !bus.start;
    assign accept   = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    // addr_q is always the address of the held (or next) word, so it only
    // moves when a word leaves the output stage.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_err_d    = out_err_q;
        addr_d       = addr_q;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + ADDR_W'(ADDR_STEP);
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_word_d  = pack_word;
            out_err_d   = pack_err;
            if (pack_err) begin
                err_sticky_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
        end

        if (bus.start) begin
            out_valid_d  = 1'b0;
            addr_d       = BASE_ADDR;
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_word_q   <= NOP_WORD;
            out_err_q    <= 1'b0;
            addr_q       <= BASE_ADDR;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_err_q    <= out_err_d;
            addr_q       <= addr_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_word   = out_word_q;
    assign bus.out_addr   = addr_q;
    assign bus.out_err    = out_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: doc/i_instr_encoder.md
Name: i_instr_encoder

Overview:
- Streaming encoder that packs RISC-V I-type fields (opcode class, funct3, rd, rs1, signed immediate) into 32-bit instruction words. It is the inverse of the I-type field decoder.
- Emits each word with a sequential instruction-memory write address. Used by the program loader and the self-test generator to fill instruction memory.
- Valid/ready handshake on both sides; one-entry registered output stage; sticky error reporting.

Parameters:
- ADDR_W, 32, width of the output write address.
- BASE_ADDR, 32'h0000_0000, first address after reset or restart.
- ADDR_STEP, 4, address increment per emitted word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; reloads address to BASE_ADDR and clears errors.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- in_op  input  2  00 OP-IMM, 01 LOAD, 10 JALR, 11 reserved.
- in_funct3  input  3  funct3 field.
- in_arith  input  1  selects SRAI for OP-IMM funct3=101.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register.
- in_imm  input  32  signed immediate, or shamt for shifts.
- out_valid  output  1  word/address valid.
- out_ready  input  1  downstream accepts.
- out_word  output  32  encoded instruction.
- out_addr  output  ADDR_W  write address for out_word.
- out_err  output  1  the held word is a substituted NOP.
- err_sticky  output  1  set on any error since rst/start.
- err_count  output  8  errors since rst/start, saturates at 255.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - out_valid=0, out_word=32'h0000_0013, out_addr=BASE_ADDR, out_err=0.
  - err_sticky=0, err_count=0, in_ready=1.
- Handshake and latency:
  - in_ready = !out_valid | out_ready (combinational).
  - Input handshake (in_valid & in_ready) loads the output register next edge: latency 1 cycle.
  - Full throughput when out_ready stays high.
  - While out_valid & !out_ready: out_word, out_addr and out_err are held stable, and in_ready=0.
- Address:
  - Each output handshake (out_valid & out_ready) advances the address for the next word by ADDR_STEP.
  - Wraps modulo 2^ADDR_W with no flag.
  - The first emitted word after reset or start carries BASE_ADDR.
- Encoding: word = imm12[31:20] | rs1[19:15] | funct3[14:12] | rd[11:7] | opcode[6:0].
  - Opcodes: OP-IMM 7'h13, LOAD 7'h03, JALR 7'h67.
  - Non-shift imm12 = in_imm[11:0]. The value is legal only if in_imm lies in -2048..2047 (bits 31:11 all equal).
  - Shifts (OP-IMM, funct3 001 or 101): shamt = in_imm, legal 0..31.
  - imm12 = {funct7, shamt}. funct7 = 7'b0100000 only for funct3=101 with in_arith=1; otherwise 0.
  - in_arith is ignored outside OP-IMM funct3=101.
- Errors. Each of the following substitutes NOP 32'h0000_0013 and sets out_err=1:
  - immediate out of range;
  - in_op=11;
  - JALR with funct3≠000;
  - LOAD with funct3 in {011,110,111};
  - shift shamt out of range.
- Error side effects:
  - The substituted word still consumes an address.
  - err_sticky is set and err_count increments (saturating) on the accepting edge.
- start behaviour:
  - start has priority over a same-cycle input handshake. The input is not accepted: in_ready is forced 0 while start=1.
  - start drops out_valid; any held word is discarded.
  - Address reloads to BASE_ADDR, and err_sticky and err_count clear.
- rst mid-transfer: the pending word is discarded and everything returns to reset values on the next edge.

Decomposition:
- Shared package: opcode constants (OPC_OP_IMM, OPC_LOAD, OPC_JALR), NOP_WORD, in_op encodings, FUNCT7_SRA.
- Sub-module i_instr_pack (combinational): fields in, word and error flag out.
- The top level holds the handshake register, address counter and error counters.

Test Plan:
- addi x1,x2,-1 (op=00,f3=000,rd=1,rs1=2,imm=-1) -> out_word 32'hFFF1_0093, out_addr 0, out_err=0.
- lw x5,8(x10) followed back-to-back by srai x3,x4,7 with out_ready=1 ->
  - 32'h0085_2283 at addr 0;
  - then 32'h4072_5193 at addr 4, one word per cycle.
- addi with imm=2048, then JALR f3=001 -> two NOPs 32'h0000_0013 with out_err=1; err_sticky=1, err_count=2.
- out_ready held low 3 cycles with in_valid high ->
  - out_word and out_addr stable and in_ready=0 throughout;
  - the next word follows one cycle after out_ready rises.
- start asserted during a held word, same cycle as in_valid ->
  - out_valid=0 next cycle and that input is not accepted;
  - the next word carries addr BASE_ADDR, err_count=0.
- rst pulsed while out_valid=1 -> all outputs at reset values next cycle; address sequence restarts at BASE_ADDR.
